// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard tracker.
// An in-flight write record carries its destination zero-extended to a fixed
// width so the same struct serves any ADDR_W up to FWD_ADDR_MAX_W.
package fwd_pkg;

  localparam int FWD_ADDR_MAX_W = 8;

  // Architectural zero register (x0), in the widened record format.
  localparam logic [FWD_ADDR_MAX_W-1:0] FWD_X0_ADDR = '0;

  typedef struct packed {
    logic                      valid;
    logic [FWD_ADDR_MAX_W-1:0] addr;
    logic                      mem;
  } fwd_entry_t;

  // Empty slot used for bubbles and flushed positions.
  function automatic fwd_entry_t fwd_empty_entry();
    fwd_entry_t e;
    e = '0;
    return e;
  endfunction

endpackage

// File: rtl/fwd_tracker_src.sv
// Per-source priority match over the in-flight write records.
// Index 0 of entries_i is prev1 (youngest). The youngest matching record wins
// and shadows every older one, including when the winner forces a stall.
module fwd_tracker_src
  import fwd_pkg::*;
#(
  parameter int DEPTH              = 3,
  parameter int ADDR_W             = 5,
  parameter int MEM_LAT            = 2,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  fwd_entry_t [DEPTH-1:0] entries_i,
  input  logic [ADDR_W-1:0]      src_addr_i,
  input  logic                   src_use_i,
  output logic [DEPTH-1:0]       take_prev_o,
  output logic                   take_mem_o,
  output logic                   stall_o
);

  logic                      hit;
  logic                      x0_blocked;
  logic [FWD_ADDR_MAX_W-1:0] addr_ext;

  // Youngest-first search; the first hit locks out all older records.
  always_comb begin
    take_prev_o = '0;
    take_mem_o  = 1'b0;
    stall_o     = 1'b0;
    hit         = 1'b0;
    addr_ext    = FWD_ADDR_MAX_W'(src_addr_i);
    x0_blocked  = (ZERO_REG_HARDWIRED != 0) && (addr_ext == FWD_X0_ADDR);
    for (int k = 0; k < DEPTH; k++) begin
      if (!hit && src_use_i && !x0_blocked &&
          entries_i[k].valid && (entries_i[k].addr == addr_ext)) begin
        hit            = 1'b1;
        take_prev_o[k] = 1'b1;
        if (entries_i[k].mem) begin
          // Stage k+1 (1-based) has the load data only from MEM_LAT onward.
          if (k + 1 >= MEM_LAT) take_mem_o = 1'b1;
          else                  stall_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_tracker.sv
// Hazard/forwarding tracker sitting beside decode/issue.
// Keeps a shift register of in-flight write records and, per source operand,
// returns a one-hot forward select, a take-from-memory flag and a load-use
// stall. Optional stall statistics are enabled by defining
// FWD_TRACKER_STATS_EN; otherwise stall_count is tied to zero.
module fwd_tracker
  import fwd_pkg::*;
#(
  parameter int NUM_SRC            = 2,
  parameter int DEPTH              = 3,
  parameter int ADDR_W             = 5,
  parameter int MEM_LAT            = 2,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic                        issue_write,
  input  logic [ADDR_W-1:0]           issue_write_addr,
  input  logic                        issue_mem,
  input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]          src_use,
  input  logic                        freeze,
  input  logic                        flush,
  input  logic [DEPTH-1:0]            flush_mask,
  output logic                        stall,
  output logic [NUM_SRC*DEPTH-1:0]    take_prev,
  output logic [NUM_SRC-1:0]          take_mem,
  output logic [31:0]                 stall_count
);

  if (ADDR_W > FWD_ADDR_MAX_W) begin : g_addr_w_check
    $error("fwd_tracker: ADDR_W exceeds FWD_ADDR_MAX_W");
  end
  if (MEM_LAT < 1 || MEM_LAT > DEPTH) begin : g_mem_lat_check
    $error("fwd_tracker: MEM_LAT must lie in 1..DEPTH");
  end

  fwd_entry_t [DEPTH-1:0] entries_q;
  fwd_entry_t [DEPTH-1:0] entries_d;
  logic [NUM_SRC-1:0]     src_stall;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_tracker_src #(
      .DEPTH              (DEPTH),
      .ADDR_W             (ADDR_W),
      .MEM_LAT            (MEM_LAT),
      .ZERO_REG_HARDWIRED (ZERO_REG_HARDWIRED)
    ) u_src (
      .entries_i   (entries_q),
      .src_addr_i  (src_addr[g*ADDR_W +: ADDR_W]),
      .src_use_i   (src_use[g]),
      .take_prev_o (take_prev[g*DEPTH +: DEPTH]),
      .take_mem_o  (take_mem[g]),
      .stall_o     (src_stall[g])
    );
  end

  // A waiting producer only matters if an instruction is actually issuing.
  assign stall = issue_valid && (|src_stall);

  // Next scoreboard contents: freeze holds, flush beats stall beats normal.
  always_comb begin
    entries_d = entries_q;
    if (!freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      if (flush) begin
        entries_d[0] = fwd_empty_entry();
        for (int k = 0; k < DEPTH; k++) begin
          if (flush_mask[k]) entries_d[k].valid = 1'b0;
        end
      end else if (stall) begin
        entries_d[0] = fwd_empty_entry();
      end else begin
        entries_d[0].valid = issue_valid && issue_write;
        entries_d[0].addr  = FWD_ADDR_MAX_W'(issue_write_addr);
        entries_d[0].mem   = issue_mem;
      end
    end
  end

  // Scoreboard register; reset only needs to clear the valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries_q[k].valid <= 1'b0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

`ifdef FWD_TRACKER_STATS_EN
  logic [31:0] stall_count_q;

  // Count cycles where issue is really held by a load-use hazard; saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (stall && !freeze && !flush && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: doc/fwd_tracker.md
Name: fwd_tracker

Overview:
Parametrised hazard/forwarding unit for the pipelined RISC-V core. It sits beside the decode/issue stage.
- Holds its own shift register of in-flight write records (the scoreboard) rather than taking per-stage write info as ports.
- Per source operand, returns a one-hot forward select over the pipeline depth plus a take-from-memory flag.
- Raises stall when a memory result is not yet available, inserts a bubble, and supports freeze and flush.

Parameters:
NUM_SRC, 2, number of source operands checked per issue.
DEPTH, 3, number of tracked in-flight stages (prev1..prevDEPTH).
ADDR_W, 5, register address width.
MEM_LAT, 2, first stage index (1-based) at which a load result is forwardable; legal range 1..DEPTH.
ZERO_REG_HARDWIRED, 1, when 1, address 0 never matches and never stalls.

Ports:
clk  in  1  core clock.
reset  in  1  synchronous, active-high reset.
issue_valid  in  1  instruction present in issue stage.
issue_write  in  1  issuing instruction writes a register.
issue_write_addr  in  ADDR_W  its destination.
issue_mem  in  1  its result comes from memory (load).
src_addr  in  NUM_SRC*ADDR_W  packed source addresses; source i at [i*ADDR_W +: ADDR_W].
src_use  in  NUM_SRC  source i is actually read.
freeze  in  1  whole pipeline held (e.g. memory busy).
flush  in  1  kill issuing instruction and entries selected by flush_mask.
flush_mask  in  DEPTH  bit k-1 set: invalidate prevk on flush.
stall  out  1  issue must hold; a bubble is recorded.
take_prev  out  NUM_SRC*DEPTH  one-hot per source; bit k-1 = forward from prevk.
take_mem  out  NUM_SRC  forward the memory-stage value, not the ALU value.
stall_count  out  32  stall-cycle counter (see optional feature).

Behaviour:
- Entry k (1..DEPTH) holds {valid, addr, mem}; entry 1 is the youngest. Reset clears all valid bits to 0.
- Outputs are combinational from the entries and the src_* inputs; there is no output latency. Reset outputs: stall=0, take_prev=0, take_mem=0, stall_count=0.
- Match k for source i: src_use[i] && valid_k && addr_k==src_addr_i, and not (ZERO_REG_HARDWIRED && src_addr_i==0).
- Priority: the youngest matching k wins. take_prev has at most one bit set per source; no match gives all-zero, meaning read the register file.
- take_mem[i] = winner's mem && k>=MEM_LAT.
- stall_i = winner's mem && k<MEM_LAT. stall = OR over all sources, gated by issue_valid. With the default parameters this reproduces the classic single-cycle load-use stall.
- A matching entry shadows older ones even when that entry causes a stall.
- Per-edge update priority: reset > freeze > flush > stall > normal.
  - freeze: all entries hold; outputs still computed.
  - flush: shift by one; the new entry 1 is invalid; any shifted entry whose destination flush_mask bit is set is invalidated. flush overrides stall.
  - stall: shift by one, inserting an invalid bubble at entry 1.
  - normal: shift by one; entry 1 = {issue_valid && issue_write, issue_write_addr, issue_mem}.
  - Entry DEPTH falls off on every shift.
- Stall resolves on its own: after MEM_LAT-k shifts the producer reaches stage MEM_LAT.
- With MEM_LAT=1, stall is constant 0.
- issue_write with a destination of 0 is recorded as-is; matching is suppressed on the source side.

Optional Feature:
FWD_TRACKER_STATS_EN
- Defined: stall_count increments by 1 on each edge where stall && !freeze && !flush && !reset. It saturates at 32'hFFFF_FFFF and is cleared by reset.
- Undefined: stall_count is tied to 0 and the counter logic is absent.

Decomposition:
- Shared package fwd_pkg: typedef fwd_entry_t {valid, addr, mem}, and a constant for the x0 address.
- One sub-module, fwd_tracker_src: the combinational per-source priority match, instantiated NUM_SRC times. It produces take_prev slice, take_mem and stall_i.

Test Plan:
- Reset then idle: after 3 cycles, with src_addr x5 used, take_prev=0, take_mem=0, stall=0.
- ALU chain: issue write x5 (mem=0), then a source reading x5 the next cycle -> take_prev[0]=1 (prev1), take_mem=0; two cycles later without new writers -> prev2, then prev3, then no forward.
- Load-use: issue load x7, then next instruction reads x7 -> stall=1 for one cycle, bubble inserted. Next cycle take_prev bit prev2=1, take_mem=1, stall=0. stall_count=1 with FWD_TRACKER_STATS_EN.
- Priority and x0:
  - ALU writes x3 at prev2, load x3 at prev1 -> stall.
  - Writes to x0 at prev1 with a source reading x0 -> no forward, no stall.
  - rs1 and rs2 both x3 -> identical selects.
- Freeze/flush:
  - Load x9 at prev1, freeze=1 for 4 cycles -> stall stays 1, entries unchanged, stall_count unchanged.
  - Then flush with flush_mask=3'b010 -> load entry (shifting to prev2) invalidated, source x9 gets no forward.
- MEM_LAT=3, DEPTH=4 instance: load x4 then reader -> stall 2 consecutive cycles, then take_prev prev3 with take_mem=1.
